// File: rtl/rr_mux_4to1_pkg.sv
// mux_pkg: shared constants and helpers for the four-channel round-robin mux.
//   NUM_CH         number of input channels
//   SEL_W          width of a channel index
//   DATA_W_DEF     default data word width
//   onehot_to_idx  converts a one-hot channel vector into its channel index
package mux_pkg;

    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;
    localparam int DATA_W_DEF = 8;

    // An all-zero vector returns 0.
    // Callers only act on the result when some bit is set.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_4to1_arbiter.sv
// rr_arbiter_4: purely combinational round-robin arbiter over four requesters.
//   req  [3:0]  request vector, bit i = channel i
//   last [1:0]  index of the most recent grant
//   gnt  [3:0]  one-hot grant, zero when nothing requests
// Priority starts at last+1 and climbs upward, wrapping from 3 to 0.
module rr_arbiter_4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [NUM_CH-1:0] gnt
);

    logic [SEL_W-1:0]    start;
    logic [2*NUM_CH-1:0] doubled;
    logic [NUM_CH-1:0]   rotated;
    logic [NUM_CH-1:0]   first;
    logic [SEL_W-1:0]    offset;
    logic [SEL_W-1:0]    winner;

    // The request vector is rotated so that the highest-priority channel
    // lands in bit 0. The lowest set bit is then the winner. Its offset is
    // added back to the start index, and the 2-bit sum wraps the rotation
    // for free.
    always_comb begin
        start   = last + SEL_W'(1);
        doubled = {req, req} >> start;
        rotated = doubled[NUM_CH-1:0];
        first   = rotated & (~rotated + NUM_CH'(1));
        offset  = onehot_to_idx(first);
        winner  = start + offset;
        gnt     = '0;
        if (|req) begin
            gnt = NUM_CH'(1) << winner;
        end
    end

endmodule

// File: rtl/rr_mux_4to1.sv
// rr_mux_4to1: merges four valid/ready streams into one registered output
// stream. Each output word is tagged with its source channel.
//   clk, rst     clock and synchronous active-high reset
//   in_valid     per-channel valid
//   in_data      channel i occupies bits [i*DATA_W +: DATA_W]
//   in_ready     per-channel ready, combinational, one-hot or zero
//   out_valid    output register holds a word
//   out_data     registered data word
//   out_sel      registered source channel of out_data
//   out_ready    consumer accepts the word when out_valid is also high
module rr_mux_4to1
    import mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  last_grant;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              load;

    rr_arbiter_4 u_arbiter (
        .req  (in_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    // A new word can enter when the register is empty or being drained on
    // this same edge. This allows one word per cycle under continuous flow.
    // Reset blocks loading so that no producer believes a beat was taken
    // during the reset cycle.
    always_comb begin
        load     = !rst && (!out_valid || out_ready) && (|in_valid);
        in_ready = load ? gnt : '0;
        gnt_idx  = onehot_to_idx(gnt);
        gnt_data = in_data[gnt_idx*DATA_W +: DATA_W];
    end

    // Output register and round-robin pointer.
    // last_grant moves only on a load, so a stalled output freezes the
    // rotation. A drain with nothing to load clears valid but keeps the
    // previous data and channel tag visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= gnt_data;
            out_sel    <= gnt_idx;
            last_grant <= gnt_idx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_4to1.sv
// tb_rr_mux_4to1: checks rr_mux_4to1 against a directed vector table, then
// against a behavioural round-robin model driven by random traffic.
module tb_rr_mux_4to1;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    int check_cnt;
    int pass_cnt;

    rr_mux_4to1 #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[22];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called shortly after a rising edge.
    // It drives the inputs, checks in_ready mid-cycle, then crosses the next
    // edge and checks the registered outputs.
    task automatic applyStimulus(input string tag, input logic r, input logic [3:0] v,
                                 input logic [31:0] d, input logic ordy,
                                 input logic [3:0] exp_ready, input logic exp_valid,
                                 input logic [7:0] exp_data, input logic [1:0] exp_sel);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #2;
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        checkOutput({tag, ".out_data"}, 32'(out_data), 32'(exp_data));
        checkOutput({tag, ".out_sel"}, 32'(out_sel), 32'(exp_sel));
    endtask

    // Reference model: the next channel after the previous grant that has
    // a request, counting upward modulo 4. Returns -1 if none.
    function automatic int pickChannel(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    int          m_last;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  m_sel;
    logic [3:0]  pend_v;
    logic [7:0]  pend_d[4];

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        check_cnt = 0;
        pass_cnt = 0;

        // Reset, rotation, sparse requesters, backpressure, drain, mid-stream reset.
        vecs[0]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[2]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[3]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        vecs[4]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
        vecs[5]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
        vecs[6]  = '{1'b0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        vecs[7]  = '{1'b0, 4'b0010, 32'h0000B100, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[8]  = '{1'b0, 4'b1010, 32'hB300B100, 1'b1, 4'b1000, 1'b1, 8'hB3, 2'd3};
        vecs[9]  = '{1'b0, 4'b1010, 32'hB300B100, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
        vecs[10] = '{1'b0, 4'b1010, 32'hB300B100, 1'b1, 4'b1000, 1'b1, 8'hB3, 2'd3};
        vecs[11] = '{1'b0, 4'b0100, 32'h005C0000, 1'b1, 4'b0100, 1'b1, 8'h5C, 2'd2};
        vecs[12] = '{1'b0, 4'b0100, 32'h005C0000, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2};
        vecs[13] = '{1'b0, 4'b0100, 32'h005C0000, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2};
        vecs[14] = '{1'b0, 4'b0100, 32'h005C0000, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2};
        vecs[15] = '{1'b0, 4'b1101, 32'hD35C00D0, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
        vecs[16] = '{1'b0, 4'b0001, 32'h00000011, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[17] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        vecs[18] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        vecs[19] = '{1'b0, 4'b0010, 32'h00002200, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[20] = '{1'b1, 4'b0010, 32'h00002200, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[21] = '{1'b0, 4'b1111, 32'hA3A2A1A0, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].rst, vecs[i].v, vecs[i].d,
                          vecs[i].ordy, vecs[i].exp_ready, vecs[i].exp_valid,
                          vecs[i].exp_data, vecs[i].exp_sel);
        end

        // Hand-written sequence: back-to-back stall and release with all four
        // channels requesting. The pointer must stay at 0 through the stall.
        // Grants then continue 1, 2.
        applyStimulus("hold0", 1'b0, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
        applyStimulus("hold1", 1'b0, 4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
        applyStimulus("rel0",  1'b0, 4'b1111, 32'hC3C2C1C0, 1'b1, 4'b0010, 1'b1, 8'hC1, 2'd1);
        applyStimulus("rel1",  1'b0, 4'b1101, 32'hC3C2C1C0, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);

        // Random traffic against the model.
        // Producers hold each word until the model says it was taken.
        applyStimulus("rreset", 1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        m_last  = 3;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = '0;
        pend_v  = '0;
        for (int n = 0; n < 4; n++) pend_d[n] = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        r;
            logic        ordy;
            logic [31:0] d;
            logic [3:0]  er;
            int          ch;
            for (int n = 0; n < 4; n++) begin
                if (!pend_v[n] && ($urandom_range(0, 1) == 1)) begin
                    pend_v[n] = 1'b1;
                    pend_d[n] = 8'($urandom);
                end
            end
            r    = ($urandom_range(0, 31) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            d    = {pend_d[3], pend_d[2], pend_d[1], pend_d[0]};
            ch   = -1;
            if (!r && (!m_valid || ordy)) ch = pickChannel(pend_v, m_last);
            er = (ch >= 0) ? 4'(1 << ch) : 4'b0000;
            if (r) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_sel   = '0;
                m_last  = 3;
            end else if (ch >= 0) begin
                m_valid   = 1'b1;
                m_data    = pend_d[ch];
                m_sel     = 2'(ch);
                m_last    = ch;
                pend_v[ch] = 1'b0;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            applyStimulus($sformatf("rnd%0d", cyc), r, pend_v | er, d, ordy, er, m_valid, m_data, m_sel);
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/rr_mux_4to1.md
# rr_mux_4to1

Four-channel round-robin multiplexer with valid/ready handshakes on every port. It merges four independent input streams into one registered output stream and tags each word with its source channel index. It is the gathering counterpart of the 1-to-4 demultiplexer: a downstream demux can route words back out by feeding `out_sel` to its `sel` input. It sits between per-channel producers and a shared single-lane consumer.

## Interface
- `DATA_W`, default 8: width of each channel's data word.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `in_valid`  input  4  per-channel valid; bit i belongs to channel i.
- `in_data`  input  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  output  4  per-channel ready; combinational, one-hot or zero.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  DATA_W  registered data word.
- `out_sel`  output  2  registered source channel index of `out_data`.
- `out_ready`  input  1  consumer accepts the word on this edge when `out_valid` is also high.

## Operation
- Transfer rule: a beat moves on any edge where valid and ready are both high, on either side.
- Output register is one entry. `load = (!out_valid || out_ready) && |in_valid`.
- Arbiter is round-robin over requesters `in_valid`. It starts searching at `last_grant+1` (mod 4) and increments upward with wrap-around (3 wraps to 0).
- Grant `g` is one-hot. `in_ready = load ? g : 4'b0000`. At most one channel is accepted per cycle.
- On load, the next edge writes `in_data[g]` to `out_data` and `idx(g)` to `out_sel`, sets `out_valid` = 1, and sets `last_grant` = idx(g).
- If the register drains (`out_valid && out_ready`) and there is no requester, the next edge sets `out_valid` = 0. `out_data` and `out_sel` hold their last values.
- If `out_valid && !out_ready`, all output state holds and `in_ready` = 0. The arbiter pointer does not advance.
- Simultaneous drain and load in one cycle sustains full throughput: one word per cycle.
- `last_grant` changes only on a load. Fairness is enforced: a continuously requesting channel waits at most 3 grants.
- Producers must hold `in_valid`/`in_data` stable until accepted. The block does not check this.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `last_grant`=3 (so channel 0 has first priority), `in_ready`=0 while `rst` is high.
- Reset asserted mid-transfer discards the held word on that edge. No beat is accepted on any input during the reset cycle.
- Latency is 1 cycle: a word accepted at edge N is visible on `out_data`/`out_sel`, with `out_valid`=1, after edge N.
- `in_ready` has a combinational path from `out_ready` and `in_valid`. There is no combinational path from `in_*` to `out_*`.
- Sustained throughput is 1 word/cycle while `out_ready`=1 and any channel requests.

## Structure
- Shared package `mux_pkg` holds:
  - `NUM_CH` = 4 and `SEL_W` = 2.
  - Default `DATA_W`.
  - A `onehot_to_idx` function used by both the mux and the arbiter.
- Sub-module `rr_arbiter_4`: inputs `req[3:0]`, `last[1:0]`; output `gnt[3:0]`. Purely combinational, with rotate-priority logic.
- The top level holds the output register, `last_grant`, and the load/ready logic.

## Test plan
- Reset check: hold `rst`=1 with all `in_valid`=1 -> `out_valid`=0, `in_ready`=0000. After release, the first beat comes from channel 0.
- Rotation: all four valid with data 0xA0..0xA3, `out_ready`=1 -> `out_sel` sequence 0,1,2,3,0 on consecutive cycles. `out_data` sequence A0,A1,A2,A3.
- Sparse requesters: only channels 1 and 3 valid, previous grant 1 -> grants alternate 3,1,3. `in_ready` is never asserted for channels 0 or 2.
- Backpressure: hold `out_ready`=0 for 3 cycles with channel 2 valid (0x5C) -> `out_data`=0x5C held, `in_ready`=0000, pointer frozen. On release, the word drains and the next grant follows 2.
- Drain to empty: a single beat on channel 0 (0x11), then no valids -> `out_valid` is high for exactly one cycle, then 0. `out_sel`=0 is retained.
- Reset mid-stream: assert `rst` while `out_valid`=1 and `out_ready`=0 -> next cycle `out_valid`=0, `out_data`=0, and priority is back at channel 0.
